fft_bitrev_reorder: RTL
=======================

// Module: fft_bitrev_reorder
// PURPOSE
//   Ping-pong reorder buffer directly downstream of the 64-point SDF FFT.
//   - The FFT emits each 64-sample frame in bit-reversed order.
//   - This block emits every frame in natural subcarrier order as a contiguous
//     64-cycle burst, tagged with its subcarrier index, for the equaliser/demapper.
//   - Sample values pass through unchanged; the FFT already applied 1/N scaling.
// PARAMETERS
//   WIDTH  16  bit width of each real/imag sample
//   LOG2N  6   log2 of the FFT size; N = 1<<LOG2N = 64
// PORTS
//   clock   in   1      master clock; all logic on the rising edge
//   reset   in   1      asynchronous, active-high reset
//   di_en   in   1      input sample valid (FFT do_en); may have gaps
//   di_re   in   WIDTH  input real part, bit-reversed order
//   di_im   in   WIDTH  input imaginary part, bit-reversed order
//   do_en   out  1      output sample valid; high for exactly N consecutive cycles per frame
//   do_re   out  WIDTH  output real part, natural order
//   do_im   out  WIDTH  output imaginary part, natural order
//   do_idx  out  LOG2N  subcarrier index of the current output sample
// BEHAVIOUR
//   Reset: do_en=0, do_re=0, do_im=0, do_idx=0; write counter=0; write bank=0;
//     both bank-full flags=0; read active=0. RAM contents are not cleared.
//   Write side: on each di_en, store sample at RAM[wbank][bitrev(wcnt)], then wcnt++.
//     - When wcnt wraps N-1->0: set full[wbank] and toggle wbank.
//     - Samples without di_en are ignored.
//   Read side: idle until some full[b]=1. Then read N consecutive cycles at
//     addresses 0..N-1 from bank b. Clear full[b] on the last read.
//     - If the other bank is already full at that point, the next burst starts the
//       following cycle, with no bubble.
//   Latency: the edge capturing the 64th sample is E0. RAM read occurs at E1, the
//     output register loads at E2. do_en first goes high after E2 (2 cycles).
//     - With contiguous input, the first do_en follows the first di_en by N+2 cycles.
//   Output register: do_en/do_re/do_im/do_idx are registered.
//     - When do_en=0, do_re/do_im hold their last value and do_idx returns to 0.
//   No overflow is possible:
//     - Filling a bank takes at least N cycles; a read burst takes exactly N.
//     - So a bank is always drained before it is rewritten. No backpressure port.
//   Simultaneous events:
//     - The last write into bank A and the last read of bank B in the same cycle
//       are legal. The burst from A follows with no gap.
//     - A write and a read of the same bank never coincide.
//   Reset mid-operation:
//     - Any partial frame is discarded and any read burst is aborted.
//     - do_en drops immediately (asynchronous).
//     - The first frame after reset starts at wcnt=0 in bank 0.
// CONFIGURATION
//   FFT_REORDER_FFTSHIFT_EN
//     defined:   read address = n XOR (N/2). The burst runs subcarriers
//                N/2..N-1, then 0..N/2-1 (DC centred). do_idx carries the true
//                subcarrier index (32..63, 0..31).
//     undefined: plain natural order 0..N-1; do_idx = 0..N-1.
//     Latency and do_en timing are identical in both builds.
// STRUCTURE
//   Package ofdm_fft_pkg: FFT_LOG2N=6, FFT_N=64, SAMPLE_W=16, function bitrev(LOG2N).
//     Shared with FFT64/IFFT64 instantiation sites.
//   Sub-module fft_reorder_ram:
//     - Simple dual-port RAM, 2*N x 2*WIDTH, one write port and one synchronous read port.
//     - Address = {bank, index}.
//   Top level holds the write counter, bank toggle, full flags, read counter and output register.
// TESTING
//   1 One frame, contiguous, input p carries re=p, im=-p (p=0..63):
//     -> after N+2 cycles, 64 contiguous do_en; output n has re=bitrev6(n): 0,32,16,48,8...
//     -> do_idx = 0..63.
//   2 Three back-to-back contiguous frames:
//     -> do_en high for 192 consecutive cycles, no gaps.
//     -> per-frame data correct, with frame offset re=p+64f.
//   3 di_en every other cycle for one frame:
//     -> output burst still 64 contiguous cycles, starting 2 cycles after the 64th sample.
//   4 Reset after 30 samples, then one full frame:
//     -> no output from the partial frame; the new frame comes out correctly in bank 0.
//   5 Reset asserted mid-burst (output n=20):
//     -> do_en=0 and do_idx=0 at once; no further output until a new full frame.
//   6 With FFT_REORDER_FFTSHIFT_EN:
//     -> do_idx sequence 32..63, 0..31; re at each index equals the scenario-1 value for that index.

Source files
------------

// File: rtl/ofdm_fft_pkg.sv
// ofdm_fft_pkg: FFT sizing constants and bit-reversal helper
// shared by the FFT64/IFFT64 sites and the reorder buffer.
package ofdm_fft_pkg;

  localparam int FFT_LOG2N = 6;
  localparam int FFT_N     = 1 << FFT_LOG2N;
  localparam int SAMPLE_W  = 16;

  // Reverse the low w bits of v; bits above w are returned as 0.
  function automatic logic [31:0] bitrev(
    input logic [31:0] v,
    input int unsigned w
  );
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < int'(w)) r[i] = v[int'(w) - 1 - i];
    end
    return r;
  endfunction

endpackage

// File: rtl/fft_reorder_ram.sv
// fft_reorder_ram: simple dual-port RAM, one write port and
// one synchronous read port (rdata valid the cycle after re).
// Ports: clock; we/waddr/wdata write; re/raddr read; rdata.
module fft_reorder_ram #(
  parameter int DW = 32,
  parameter int AW = 7
) (
  input  logic          clock,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [2**AW];

  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong buffer turning bit-reversed FFT
// frames into natural-order 64-cycle bursts tagged by index.
// Ports: clock, reset (async, active high); di_en/di_re/di_im
//   bit-reversed input; do_en/do_re/do_im/do_idx registered
//   natural-order output.
// Option: FFT_REORDER_FFTSHIFT_EN emits N/2..N-1 then 0..N/2-1.
module fft_bitrev_reorder
  import ofdm_fft_pkg::*;
#(
  parameter int WIDTH = SAMPLE_W,
  parameter int LOG2N = FFT_LOG2N
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             di_en,
  input  logic [WIDTH-1:0] di_re,
  input  logic [WIDTH-1:0] di_im,
  output logic             do_en,
  output logic [WIDTH-1:0] do_re,
  output logic [WIDTH-1:0] do_im,
  output logic [LOG2N-1:0] do_idx
);

  localparam int N = 1 << LOG2N;
  localparam logic [LOG2N-1:0] LAST = LOG2N'(N - 1);
`ifdef FFT_REORDER_FFTSHIFT_EN
  localparam logic [LOG2N-1:0] SHIFT = LOG2N'(N / 2);
`else
  localparam logic [LOG2N-1:0] SHIFT = '0;
`endif

  logic [LOG2N-1:0] wcnt;
  logic             wbank;
  logic [1:0]       full;
  logic [1:0]       full_nxt;
  logic             wr_wrap;
  logic [LOG2N:0]   waddr;

  logic             ractive;
  logic             rbank;
  logic [LOG2N-1:0] rcnt;
  logic             rd_go;
  logic             rd_bank;
  logic             rd_last;
  logic             other_ready;
  logic [LOG2N-1:0] rd_sub;

  logic             rd_valid;
  logic [LOG2N-1:0] rd_idx;
  logic [2*WIDTH-1:0] rdata;

  always_comb begin
    wr_wrap = di_en && (wcnt == LAST);
    waddr   = {wbank, LOG2N'(bitrev(32'(wcnt), LOG2N))};
  end

  // Bank 0 wins when idle; both can only be full mid-burst.
  // A bank completing this very edge still counts as ready,
  // so back-to-back bursts have no bubble.
  always_comb begin
    rd_go       = ractive | (|full);
    rd_bank     = ractive ? rbank : ~full[0];
    rd_last     = rd_go && (rcnt == LAST);
    rd_sub      = rcnt ^ SHIFT;
    other_ready = full[~rd_bank] |
                  (wr_wrap && (wbank == ~rd_bank));
    full_nxt    = full;
    if (wr_wrap) full_nxt[wbank] = 1'b1;
    if (rd_last) full_nxt[rd_bank] = 1'b0;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wcnt    <= '0;
      wbank   <= 1'b0;
      full    <= '0;
      ractive <= 1'b0;
      rbank   <= 1'b0;
      rcnt    <= '0;
    end else begin
      full <= full_nxt;
      if (di_en) begin
        wcnt <= wcnt + 1'b1;
        if (wr_wrap) wbank <= ~wbank;
      end
      if (rd_go) begin
        rcnt <= rcnt + 1'b1;
        if (rd_last) begin
          ractive <= other_ready;
          rbank   <= ~rd_bank;
        end else begin
          ractive <= 1'b1;
          rbank   <= rd_bank;
        end
      end
    end
  end

  fft_reorder_ram #(
    .DW(2 * WIDTH),
    .AW(LOG2N + 1)
  ) u_ram (
    .clock (clock),
    .we    (di_en),
    .waddr (waddr),
    .wdata ({di_re, di_im}),
    .re    (rd_go),
    .raddr ({rd_bank, rd_sub}),
    .rdata (rdata)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_valid <= 1'b0;
      rd_idx   <= '0;
    end else begin
      rd_valid <= rd_go;
      rd_idx   <= rd_sub;
    end
  end

  // Sample values hold between bursts; the index parks at 0.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      do_en  <= 1'b0;
      do_re  <= '0;
      do_im  <= '0;
      do_idx <= '0;
    end else begin
      do_en  <= rd_valid;
      do_idx <= rd_valid ? rd_idx : '0;
      if (rd_valid) begin
        do_re <= rdata[2*WIDTH-1:WIDTH];
        do_im <= rdata[WIDTH-1:0];
      end
    end
  end

endmodule
